// File: rtl/dma_channel_scheduler.sv
// Round-robin DMA command scheduler for a shared AHB-Lite read master.
// Holds each grant until the master FIFO can take the whole buffer.
module dma_channel_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int LEN_W   = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [NUM_CH-1:0]         i_ch_req,
  input  logic [NUM_CH*16-1:0]      i_ch_addr_high,
  input  logic [NUM_CH*16-1:0]      i_ch_addr_low,
  input  logic [NUM_CH*LEN_W-1:0]   i_ch_len,
  input  logic [LEN_W:0]            i_fifo_free,
  input  logic                      i_Master_Done,
  output logic                      o_NewCommandOn,
  output logic [LEN_W-1:0]          o_RCC_BUFFER_LENGTH,
  output logic [15:0]               o_RCC_DMA_ADDR_HIGH,
  output logic [15:0]               o_RCC_DMA_ADDR_LOW,
  output logic [NUM_CH-1:0]         o_ch_ack,
  output logic [NUM_CH-1:0]         o_ch_done,
  output logic                      o_err_len0,
  output logic                      o_timeout,
  output logic [2:0]                o_active_ch,
  output logic                      o_busy
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, CHECK, ISSUE, BUSY, DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       rr_ptr;
  logic [2:0]       active;
  logic [TW-1:0]    timer;
  logic [LEN_W-1:0] len_q;
  logic [15:0]      hi_q;
  logic [15:0]      lo_q;
  logic             ack_q;
  logic             err_q;
  logic             to_q;

  logic [2:0]              win;
  logic                    any_req;
  logic [NUM_CH-1:0]       req_sh;
  logic [NUM_CH*16-1:0]    hi_sh;
  logic [NUM_CH*16-1:0]    lo_sh;
  logic [NUM_CH*LEN_W-1:0] len_sh;
  logic [NUM_CH-1:0]       act_oh;

  function automatic logic [2:0] wrap(input int v);
    return 3'(v % NUM_CH);
  endfunction

  // Descending scan: the lowest offset from rr_ptr is written last and wins.
  always_comb begin
    win     = rr_ptr;
    any_req = 1'b0;
    req_sh  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      req_sh = i_ch_req >> wrap(int'(rr_ptr) + i);
      if (req_sh[0]) begin
        win     = wrap(int'(rr_ptr) + i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    hi_sh  = i_ch_addr_high >> (16 * win);
    lo_sh  = i_ch_addr_low >> (16 * win);
    len_sh = i_ch_len >> (LEN_W * win);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (any_req) state_nxt = CHECK;
      CHECK: begin
        if (len_q == '0)
          state_nxt = DONE;
        else if (i_fifo_free >= {1'b0, len_q})
          state_nxt = ISSUE;
      end
      ISSUE: state_nxt = BUSY;
      BUSY: begin
        if (i_Master_Done || timer == TMAX)
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rr_ptr <= '0;
      active <= '0;
      timer  <= '0;
      len_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (state == IDLE && any_req) begin
        active <= win;
        len_q  <= len_sh[LEN_W-1:0];
        hi_q   <= hi_sh[15:0];
        lo_q   <= lo_sh[15:0];
        ack_q  <= 1'b1;
        err_q  <= 1'b0;
        to_q   <= 1'b0;
      end
      if (state == CHECK && len_q == '0)
        err_q <= 1'b1;
      if (state == ISSUE)
        timer <= '0;
      if (state == BUSY) begin
        timer <= timer + 1'b1;
        // Master completion beats a coincident timeout.
        if (!i_Master_Done && timer == TMAX)
          to_q <= 1'b1;
      end
      if (state == DONE)
        rr_ptr <= wrap(int'(active) + 1);
    end
  end

  assign act_oh = {{(NUM_CH-1){1'b0}}, 1'b1} << active;

  assign o_NewCommandOn      = (state == ISSUE);
  assign o_RCC_BUFFER_LENGTH = len_q;
  assign o_RCC_DMA_ADDR_HIGH = hi_q;
  assign o_RCC_DMA_ADDR_LOW  = lo_q;
  assign o_ch_ack            = ack_q ? act_oh : '0;
  assign o_ch_done           = (state == DONE) ? act_oh : '0;
  assign o_err_len0          = (state == DONE) && err_q;
  assign o_timeout           = (state == DONE) && to_q;
  assign o_active_ch         = active;
  assign o_busy              = (state != IDLE);

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Scoreboard bench for dma_channel_scheduler.
// Stimulus queues expected ack/strobe/done events; a monitor pops them.
module tb_dma_channel_scheduler;

  localparam int NCH = 4;
  localparam int LW  = 6;
  localparam int TO  = 16;

  localparam int K_ACK  = 0;
  localparam int K_CMD  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    int          ch;
    int          cyc;
    logic [15:0] hi;
    logic [15:0] lo;
    logic [LW-1:0] len;
    logic        err;
    logic        to;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic [NCH-1:0]    ch_req = '0;
  logic [NCH*16-1:0] ch_addr_high;
  logic [NCH*16-1:0] ch_addr_low;
  logic [NCH*LW-1:0] ch_len;
  logic [LW:0]       fifo_free = '0;
  logic              master_done = 1'b0;

  logic              new_cmd;
  logic [LW-1:0]     rcc_len;
  logic [15:0]       rcc_hi;
  logic [15:0]       rcc_lo;
  logic [NCH-1:0]    ch_ack;
  logic [NCH-1:0]    ch_done;
  logic              err_len0;
  logic              timeout;
  logic [2:0]        active_ch;
  logic              busy;

  logic [15:0]   cfg_hi [NCH];
  logic [15:0]   cfg_lo [NCH];
  logic [LW-1:0] cfg_len[NCH];

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  dma_channel_scheduler #(
    .NUM_CH (NCH),
    .LEN_W  (LW),
    .TIMEOUT(TO)
  ) dut (
    .HCLK               (HCLK),
    .HRESETn            (HRESETn),
    .i_ch_req           (ch_req),
    .i_ch_addr_high     (ch_addr_high),
    .i_ch_addr_low      (ch_addr_low),
    .i_ch_len           (ch_len),
    .i_fifo_free        (fifo_free),
    .i_Master_Done      (master_done),
    .o_NewCommandOn     (new_cmd),
    .o_RCC_BUFFER_LENGTH(rcc_len),
    .o_RCC_DMA_ADDR_HIGH(rcc_hi),
    .o_RCC_DMA_ADDR_LOW (rcc_lo),
    .o_ch_ack           (ch_ack),
    .o_ch_done          (ch_done),
    .o_err_len0         (err_len0),
    .o_timeout          (timeout),
    .o_active_ch        (active_ch),
    .o_busy             (busy)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) cyc++;

  always_comb begin
    ch_addr_high = '0;
    ch_addr_low  = '0;
    ch_len       = '0;
    for (int c = 0; c < NCH; c++) begin
      ch_addr_high[16*c +: 16] = cfg_hi[c];
      ch_addr_low[16*c +: 16]  = cfg_lo[c];
      ch_len[LW*c +: LW]       = cfg_len[c];
    end
  end

  function automatic string kname(input int k);
    if (k == K_ACK) return "ack";
    if (k == K_CMD) return "strobe";
    return "done";
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " busy"},   32'(busy), 0);
    chk({tag, " strobe"}, 32'(new_cmd), 0);
    chk({tag, " ack"},    32'(ch_ack), 0);
    chk({tag, " done"},   32'(ch_done), 0);
    chk({tag, " err"},    32'(err_len0), 0);
    chk({tag, " tmo"},    32'(timeout), 0);
    chk({tag, " len"},    32'(rcc_len), 0);
    chk({tag, " hi"},     32'(rcc_hi), 0);
    chk({tag, " lo"},     32'(rcc_lo), 0);
    chk({tag, " active"}, 32'(active_ch), 0);
  endtask

  task automatic check_ev(input int kind, input logic [NCH-1:0] vec);
    exp_t e;
    logic ok;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected %s: vec %b at cycle %0d",
               kname(kind), vec, cyc);
      return;
    end
    e  = q.pop_front();
    ok = (e.kind == kind) && (vec == (NCH'(1) << e.ch)) && (e.cyc == cyc)
      && (rcc_hi == e.hi) && (rcc_lo == e.lo) && (rcc_len == e.len)
      && (int'(active_ch) == e.ch) && busy;
    if (kind == K_DONE)
      ok = ok && (err_len0 == e.err) && (timeout == e.to);
    if (!ok) begin
      n_fail++;
      $display({"FAIL %s: got vec %b cyc %0d hi %h lo %h len %0d act %0d",
                " err %b tmo %b; expected %s ch%0d cyc %0d hi %h lo %h",
                " len %0d err %b tmo %b"},
               kname(kind), vec, cyc, rcc_hi, rcc_lo, rcc_len, active_ch,
               err_len0, timeout, kname(e.kind), e.ch, e.cyc, e.hi, e.lo,
               e.len, e.err, e.to);
    end
  endtask

  always @(posedge HCLK) begin
    #1;
    if (HRESETn) begin
      if (ch_ack != '0) check_ev(K_ACK, ch_ack);
      if (new_cmd)      check_ev(K_CMD, NCH'(1) << active_ch);
      if (ch_done != '0) check_ev(K_DONE, ch_done);
      if ((err_len0 || timeout) && ch_done == '0) begin
        n_chk++;
        n_fail++;
        $display("FAIL stray flag: err %b tmo %b at cycle %0d",
                 err_len0, timeout, cyc);
      end
    end
  end

  task automatic at(input int c);
    while (cyc < c) @(negedge HCLK);
  endtask

  task automatic push(input int kind, input int ch, input int c,
                      input logic err, input logic to);
    exp_t e;
    e.kind = kind;
    e.ch   = ch;
    e.cyc  = c;
    e.hi   = cfg_hi[ch];
    e.lo   = cfg_lo[ch];
    e.len  = cfg_len[ch];
    e.err  = err;
    e.to   = to;
    q.push_back(e);
  endtask

  task automatic run(input int ch, input int nbusy, input bit md_on,
                     input int w, input logic [NCH-1:0] drop,
                     input logic [LW:0] free_hi);
    int k;
    k = cyc + 1;
    push(K_ACK, ch, k, 1'b0, 1'b0);
    if (cfg_len[ch] == '0) begin
      push(K_DONE, ch, k + 1, 1'b1, 1'b0);
      at(k);
      ch_req = ch_req & ~drop;
      at(k + 2);
      return;
    end
    push(K_CMD, ch, k + 1 + w, 1'b0, 1'b0);
    push(K_DONE, ch, k + 2 + w + nbusy, 1'b0, !md_on);
    at(k);
    ch_req = ch_req & ~drop;
    if (drop[ch]) begin
      cfg_hi[ch]  = ~cfg_hi[ch];
      cfg_lo[ch]  = ~cfg_lo[ch];
      cfg_len[ch] = cfg_len[ch] + 1'b1;
    end
    if (w > 0) begin
      at(k + w);
      fifo_free = free_hi;
    end
    if (md_on) begin
      at(k + 1 + w + nbusy);
      master_done = 1'b1;
      at(k + 2 + w + nbusy);
      master_done = 1'b0;
    end
    at(k + 3 + w + nbusy);
  endtask

  task automatic set_cfg(input int ch, input logic [15:0] hi,
                         input logic [15:0] lo, input logic [LW-1:0] len);
    cfg_hi[ch]  = hi;
    cfg_lo[ch]  = lo;
    cfg_len[ch] = len;
  endtask

  initial begin
    exp_t e;
    int   k;
    for (int c = 0; c < NCH; c++) set_cfg(c, '0, '0, '0);

    repeat (3) @(negedge HCLK);
    chk_zero("reset");

    HRESETn   = 1'b1;
    fifo_free = 7'd32;
    set_cfg(2, 16'hA2A2, 16'h2020, 6'd8);
    ch_req = 4'b0100;
    run(2, 10, 1, 0, 4'b0100, '0);

    set_cfg(3, 16'h3333, 16'h0300, 6'd0);
    ch_req = 4'b1000;
    run(3, 0, 0, 0, 4'b1000, '0);

    set_cfg(0, 16'h1111, 16'h0100, 6'd3);
    set_cfg(1, 16'h2222, 16'h0200, 6'd17);
    set_cfg(2, 16'hA2A2, 16'h2020, 6'd8);
    set_cfg(3, 16'h3333, 16'h0300, 6'd32);
    ch_req = 4'b1111;
    for (int i = 0; i < 5; i++)
      run(i % NCH, 3, 1, 0, (i == 4) ? 4'b1111 : 4'b0000, '0);

    set_cfg(1, 16'h5A5A, 16'hC0DE, 6'd20);
    fifo_free = 7'd10;
    ch_req = 4'b0010;
    run(1, 4, 1, 14, 4'b0010, 7'd24);
    fifo_free = 7'd32;

    set_cfg(0, 16'h0F0F, 16'hF0F0, 6'd0);
    ch_req = 4'b0001;
    run(0, 0, 0, 0, 4'b0001, '0);

    set_cfg(2, 16'hBEEF, 16'h1234, 6'd5);
    ch_req = 4'b0100;
    run(2, 16, 0, 0, 4'b0100, '0);
    set_cfg(2, 16'hCAFE, 16'h4321, 6'd6);
    ch_req = 4'b0100;
    run(2, 16, 1, 0, 4'b0100, '0);

    set_cfg(1, 16'h7777, 16'h0700, 6'd4);
    ch_req = 4'b0010;
    k = cyc + 1;
    push(K_ACK, 1, k, 1'b0, 1'b0);
    push(K_CMD, 1, k + 1, 1'b0, 1'b0);
    at(k);
    ch_req = '0;
    at(k + 5);
    chk("pre-reset busy", 32'(busy), 1);
    HRESETn = 1'b0;
    #1;
    chk_zero("async reset");
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;

    set_cfg(1, 16'h1234, 16'h5678, 6'd2);
    set_cfg(3, 16'h9ABC, 16'hDEF0, 6'd9);
    ch_req = 4'b1010;
    run(1, 3, 1, 0, 4'b0010, '0);
    run(3, 3, 1, 0, 4'b1000, '0);

    repeat (4) @(negedge HCLK);
    while (q.size() != 0) begin
      e = q.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL missing %s: expected ch%0d at cycle %0d",
               kname(e.kind), e.ch, e.cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
